// File: rtl/mips_reg_file.sv
// -----------------------------------------------------------------------------
// mips_reg_file
//   MIPS-style general-purpose register file. It has 2**ADDR_WIDTH registers,
//   each DATA_WIDTH bits wide. There are two combinational read ports and one
//   write port that updates on the rising clock edge. Register 0 ($zero)
//   always reads as zero, and any write to it is discarded.
//
// Ports
//   CLK           in   clock; all state changes happen on the rising edge
//   rst           in   asynchronous active-low reset; clears every register
//   RegWrite      in   write enable, sampled on rising CLK
//   WriteAddress  in   destination register of the write
//   DataIn        in   write data
//   Address1      in   read port 1 register select
//   Address2      in   read port 2 register select
//   DataOut1      out  contents of reg[Address1] (0 when Address1 == 0)
//   DataOut2      out  contents of reg[Address2] (0 when Address2 == 0)
// -----------------------------------------------------------------------------
module mips_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteAddress,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [ADDR_WIDTH-1:0] Address1,
    input  logic [ADDR_WIDTH-1:0] Address2,
    output logic [DATA_WIDTH-1:0] DataOut1,
    output logic [DATA_WIDTH-1:0] DataOut2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_en;

    // A write to $zero is dropped here, so regs_q[0] never leaves its reset value.
    assign wr_en = RegWrite && (WriteAddress != '0);

    // NOTE: every signal assigned in a combinational block gets a default
    // first (here, the current contents). A path that leaves a signal
    // unassigned would infer a latch.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteAddress] = DataIn;
        end
    end

    // NOTE: this storage array is reset on purpose. The register file must
    // read as defined zeros straight after reset, with no X values.
    // Sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The read ports have no write bypass. A read of the register being
    // written returns the old contents until the clock edge.
    assign DataOut1 = (Address1 == '0) ? '0 : regs_q[Address1];
    assign DataOut2 = (Address2 == '0) ? '0 : regs_q[Address2];

endmodule

// File: tb/tb_mips_reg_file.sv
// -----------------------------------------------------------------------------
// tb_mips_reg_file
//   Scoreboard bench for mips_reg_file. The stimulus process drives the ports
//   and computes the expected read data from an array model of the register
//   file. It then queues an expectation and signals the monitor. The monitor
//   pops each expectation and compares it with both read ports.
// -----------------------------------------------------------------------------
module tb_mips_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK;
    logic          rst;
    logic          RegWrite;
    logic [AW-1:0] WriteAddress;
    logic [DW-1:0] DataIn;
    logic [AW-1:0] Address1;
    logic [AW-1:0] Address2;
    logic [DW-1:0] DataOut1;
    logic [DW-1:0] DataOut2;

    mips_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .RegWrite     (RegWrite),
        .WriteAddress (WriteAddress),
        .DataIn       (DataIn),
        .Address1     (Address1),
        .Address2     (Address2),
        .DataOut1     (DataOut1),
        .DataOut2     (DataOut2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a plain array holding what each register should contain.
    logic [DW-1:0] model [32];

    typedef struct {
        string         name;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int port, input logic [AW-1:0] addr,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d addr=%0d got=%h expected=%h", name, port, addr, act, exp);
        end
    endtask

    // Model side: reg 0 reads zero, and a write to address 0 has no effect.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a != 0) model[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Drive the read addresses, queue the expected data, and signal the monitor.
    task automatic expect_read(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        Address1 = a1;
        Address2 = a2;
        e.name = name;
        e.a1   = a1;
        e.a2   = a2;
        e.e1   = model_read(a1);
        e.e2   = model_read(a2);
        exp_q.push_back(e);
        #1 -> sample_ev;
        #1;
    endtask

    // Single write: apply it between edges, let one rising edge pass, update the model.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        RegWrite     = 1'b1;
        WriteAddress = a;
        DataIn       = d;
        @(posedge CLK);
        #1;
        if (rst) model_write(a, d);
        @(negedge CLK);
        RegWrite = 1'b0;
    endtask

    // Monitor: compare every queued expectation against both ports.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, 1, e.a1, DataOut1, e.e1);
                check(e.name, 2, e.a2, DataOut2, e.e2);
            end
        end
    end

    // Watchdog: the bench must always end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          we;

        rst          = 1'b0;
        RegWrite     = 1'b0;
        WriteAddress = '0;
        DataIn       = '0;
        Address1     = '0;
        Address2     = '0;
        model_clear();

        // 1: reset sweep, checked once during reset and then over all registers after release
        repeat (2) @(negedge CLK);
        expect_read("reset_low", 5'd7, 5'd31);
        rst = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 16; k++) begin
            expect_read("reset_sweep", 5'(2 * k), 5'(2 * k + 1));
        end

        // 2: $zero ignores writes
        do_write(5'd0, 32'h0001_2345);
        expect_read("zero_reg", 5'd0, 5'd0);

        // 3: basic write
        do_write(5'd1, 32'h0001_2345);
        expect_read("basic_write", 5'd1, 5'd0);

        // 4: same register on both ports
        do_write(5'd2, 32'h0012_3456);
        expect_read("same_reg_both", 5'd2, 5'd2);

        // 5: back-to-back writes to two registers
        @(negedge CLK);
        RegWrite = 1'b1; WriteAddress = 5'd3; DataIn = 32'h0123_4567;
        @(posedge CLK); #1 model_write(5'd3, 32'h0123_4567);
        @(negedge CLK);
        WriteAddress = 5'd4; DataIn = 32'h1234_5678;
        @(posedge CLK); #1 model_write(5'd4, 32'h1234_5678);
        @(negedge CLK);
        RegWrite = 1'b0;
        expect_read("two_regs", 5'd3, 5'd4);

        // Overwrite of the same register: the later value wins
        do_write(5'd3, 32'hDEAD_BEEF);
        do_write(5'd3, 32'hCAFE_F00D);
        expect_read("overwrite", 5'd3, 5'd4);

        // No bypass: old value before the edge, new value just after it
        @(negedge CLK);
        RegWrite = 1'b1; WriteAddress = 5'd4; DataIn = 32'hA5A5_5A5A;
        expect_read("no_bypass_before", 5'd4, 5'd3);
        @(posedge CLK); #1 model_write(5'd4, 32'hA5A5_5A5A);
        expect_read("no_bypass_after", 5'd4, 5'd3);
        @(negedge CLK);
        RegWrite = 1'b0;

        // 6: async reset between edges clears everything at once
        @(negedge CLK);
        #2 rst = 1'b0;
        model_clear();
        expect_read("async_reset", 5'd3, 5'd4);
        // A write held across an edge during reset must not land
        RegWrite = 1'b1; WriteAddress = 5'd9; DataIn = 32'h9999_9999;
        @(posedge CLK); #1;
        expect_read("write_in_reset", 5'd9, 5'd2);
        @(negedge CLK);
        rst = 1'b1;
        // The first rising edge after release writes
        @(posedge CLK); #1 model_write(5'd9, 32'h9999_9999);
        expect_read("write_after_reset", 5'd9, 5'd1);
        @(negedge CLK);
        RegWrite = 1'b0;

        // Randomized traffic: random writes, plus reads sampled before each edge
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            RegWrite = we; WriteAddress = wa; DataIn = wd;
            expect_read("random", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            @(posedge CLK); #1;
            if (we) model_write(wa, wd);
        end
        @(negedge CLK);
        RegWrite = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_read("final_sweep", 5'(2 * k), 5'(2 * k + 1));
        end

        #5;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
